// File: rtl/miriscv_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// One transaction in flight, round-robin on contention, timeout error response.
module miriscv_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic { IDLE, WAIT } state_t;
  typedef enum logic { INSTR, DATA } port_t;

  state_t        state_q, state_d;
  port_t         owner_q, owner_d;
  port_t         last_q, last_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic          pick_i, pick_d;
  logic          resp, tmo;
  logic [31:0]   rdata;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= IDLE;
      owner_q   <= INSTR;
      last_q    <= DATA;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    tmo_cnt_d      = tmo_cnt_q;
    pick_i         = 1'b0;
    pick_d         = 1'b0;
    resp           = 1'b0;
    tmo            = 1'b0;
    rdata          = '0;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    instr_err_o    = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    data_err_o     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Grants are gated by reset so nothing leaks out while held.
        if (arstn_i) begin
          pick_i = instr_req_i
                 & (~data_req_i | (last_q == DATA));
          pick_d = data_req_i & ~pick_i;
        end
        unique case (1'b1)
          pick_i: begin
            instr_gnt_o = 1'b1;
            mem_req_o   = 1'b1;
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
            owner_d     = INSTR;
            last_d      = INSTR;
            tmo_cnt_d   = '0;
            state_d     = WAIT;
          end
          pick_d: begin
            data_gnt_o  = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
            owner_d     = DATA;
            last_d      = DATA;
            tmo_cnt_d   = '0;
            state_d     = WAIT;
          end
          default: ;
        endcase
      end
      WAIT: begin
        resp  = mem_rvalid_i;
        tmo   = ~mem_rvalid_i & (tmo_cnt_q == TMO_LAST);
        rdata = resp ? mem_rdata_i : '0;
        if (resp || tmo) begin
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
        if (owner_q == INSTR) begin
          instr_rvalid_o = resp | tmo;
          instr_rdata_o  = rdata;
          instr_err_o    = tmo;
        end else begin
          data_rvalid_o  = resp | tmo;
          data_rdata_o   = rdata;
          data_err_o     = tmo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Bench for miriscv_mem_arbiter: directed steps then random traffic,
// checked against a transaction-level arbiter and memory model.
module tb_miriscv_mem_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        arstn_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  miriscv_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .arstn_i(arstn_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_err_o(data_err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: word memory plus arbiter bookkeeping (0=instr, 1=data)
  logic [31:0] mem [bit [31:0]];
  bit          busy, own, last;
  int          waited;
  bit          p_we;
  logic [3:0]  p_be;
  logic [31:0] p_addr, p_wdata;

  logic        m_ig, m_dg;
  logic        obs_ig, obs_dg, obs_iv, obs_ie, obs_dv, obs_de;
  logic [31:0] obs_ir, obs_dr;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a >> 2) ? mem[a >> 2] : 32'h0;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] wd);
    logic [31:0] w;
    w = rd(a);
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    mem[a >> 2] = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ignt"}, instr_gnt_o, 0);
    chk({tag, "_dgnt"}, data_gnt_o, 0);
    chk({tag, "_mreq"}, mem_req_o, 0);
    chk({tag, "_mwe"}, mem_we_o, 0);
    chk({tag, "_mbe"}, mem_be_o, 0);
    chk({tag, "_maddr"}, mem_addr_o, 0);
    chk({tag, "_mwdata"}, mem_wdata_o, 0);
    chk({tag, "_iv"}, instr_rvalid_o, 0);
    chk({tag, "_ir"}, instr_rdata_o, 0);
    chk({tag, "_ie"}, instr_err_o, 0);
    chk({tag, "_dv"}, data_rvalid_o, 0);
    chk({tag, "_dr"}, data_rdata_o, 0);
    chk({tag, "_de"}, data_err_o, 0);
  endtask

  task automatic cyc(input bit ireq, input logic [31:0] ia,
                     input bit dreq, input bit dwe,
                     input logic [3:0] dbe, input logic [31:0] da,
                     input logic [31:0] dwd, input bit rsp);
    bit g, w;
    logic [31:0] rdv;
    logic e_ig, e_dg, e_req, e_we, e_iv, e_ie, e_dv, e_de;
    logic [3:0] e_be;
    logic [31:0] e_addr, e_wd, e_ir, e_dr;
    @(negedge clk);
    instr_req_i = ireq; instr_addr_i = ia;
    data_req_i = dreq; data_we_i = dwe; data_be_i = dbe;
    data_addr_i = da; data_wdata_i = dwd;
    rdv = (busy && !p_we) ? rd(p_addr) : $urandom;
    mem_rvalid_i = rsp; mem_rdata_i = rdv;
    #1;
    {e_ig, e_dg, e_req, e_we, e_iv, e_ie, e_dv, e_de} = '0;
    e_be = '0; e_addr = '0; e_wd = '0; e_ir = '0; e_dr = '0;
    if (!busy) begin
      g = ireq || dreq;
      w = (ireq && dreq) ? !last : dreq;
      if (g) begin
        e_req = 1;
        if (!w) begin
          e_ig = 1; e_addr = ia; e_be = 4'hF; e_we = 0;
          p_we = 0; p_addr = ia;
        end else begin
          e_dg = 1; e_we = dwe; e_be = dbe; e_addr = da; e_wd = dwd;
          p_we = dwe; p_be = dbe; p_addr = da; p_wdata = dwd;
        end
        busy = 1; own = w; last = w; waited = 0;
      end
    end else if (rsp) begin
      if (!own) begin e_iv = 1; e_ir = rdv; end
      else begin e_dv = 1; e_dr = rdv; end
      if (p_we) wr(p_addr, p_be, p_wdata);
      busy = 0;
    end else if (waited == T - 1) begin
      if (!own) begin e_iv = 1; e_ie = 1; end
      else begin e_dv = 1; e_de = 1; end
      busy = 0;
    end else begin
      waited++;
    end
    chk("instr_gnt", instr_gnt_o, e_ig);
    chk("data_gnt", data_gnt_o, e_dg);
    chk("mem_req", mem_req_o, e_req);
    if (e_req) begin
      chk("mem_we", mem_we_o, e_we);
      chk("mem_be", mem_be_o, e_be);
      chk("mem_addr", mem_addr_o, e_addr);
      if (e_dg) chk("mem_wdata", mem_wdata_o, e_wd);
    end
    chk("instr_rvalid", instr_rvalid_o, e_iv);
    chk("instr_rdata", instr_rdata_o, e_ir);
    chk("instr_err", instr_err_o, e_ie);
    chk("data_rvalid", data_rvalid_o, e_dv);
    chk("data_rdata", data_rdata_o, e_dr);
    chk("data_err", data_err_o, e_de);
    obs_ig = instr_gnt_o; obs_dg = data_gnt_o;
    obs_iv = instr_rvalid_o; obs_ir = instr_rdata_o; obs_ie = instr_err_o;
    obs_dv = data_rvalid_o; obs_dr = data_rdata_o; obs_de = data_err_o;
    m_ig = e_ig; m_dg = e_dg;
  endtask

  initial begin
    bit ih, dh, rw, rsp;
    logic [3:0] rb;
    logic [31:0] ra, rda, rwd;
    arstn_i = 0; instr_req_i = 0; instr_addr_i = 0;
    data_req_i = 0; data_we_i = 0; data_be_i = 0;
    data_addr_i = 0; data_wdata_i = 0;
    mem_rvalid_i = 0; mem_rdata_i = 0;
    busy = 0; own = 0; last = 1; waited = 0;
    mem[32'h10 >> 2] = 32'h0000_0013;

    @(negedge clk); #1;
    chk_zero("reset");
    @(posedge clk); #1; arstn_i = 1;

    // single instruction fetch
    cyc(1, 32'h10, 0, 0, 0, 0, 0, 0);
    chk("fetch_gnt", obs_ig, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("fetch_rdata", obs_ir, 32'h13);
    chk("fetch_dv", obs_dv, 0);

    // data write then readback of the low half
    cyc(0, 0, 1, 1, 4'b0011, 32'h40, 32'hDEAD_BEEF, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("wr_rvalid", obs_dv, 1);
    cyc(0, 0, 1, 0, 4'hF, 32'h40, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("wr_readback", obs_dr, 32'h0000_BEEF);

    // timeout on a data read, then a late response
    cyc(0, 0, 1, 0, 4'hF, 32'h80, 0, 0);
    for (int k = 0; k < T; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("tmo_rvalid", obs_dv, 1);
    chk("tmo_err", obs_de, 1);
    chk("tmo_rdata", obs_dr, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("late_dv", obs_dv, 0);
    cyc(1, 32'h10, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("after_tmo", obs_ir, 32'h13);

    // response on the timeout cycle is a normal response
    cyc(0, 0, 1, 0, 4'hF, 32'h40, 0, 0);
    for (int k = 0; k < T - 1; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("edge_err", obs_de, 0);
    chk("edge_rdata", obs_dr, 32'h0000_BEEF);

    // reset during WAIT
    cyc(1, 32'h20, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    instr_req_i = 1; data_req_i = 1; mem_rvalid_i = 1; arstn_i = 0;
    #1;
    chk_zero("midrst");
    busy = 0; last = 1;
    @(posedge clk); #1; arstn_i = 1; mem_rvalid_i = 0;

    // continuous contention: I, D, I, D on even cycles
    for (int k = 0; k < 8; k++) begin
      cyc(1, 32'h100 + 32'(4 * k), 1, 0, 4'hF, 32'h200 + 32'(4 * k),
          0, k % 2 == 1);
      chk($sformatf("rr_c%0d", k), {obs_ig, obs_dg},
          (k % 2 == 1) ? 2'b00 : (((k / 2) % 2 == 1) ? 2'b01 : 2'b10));
    end

    // random traffic
    ih = 0; dh = 0; ra = 0; rw = 0; rb = 0; rda = 0; rwd = 0;
    for (int n = 0; n < 500; n++) begin
      if (!ih && $urandom_range(2) == 0) begin
        ih = 1; ra = 32'($urandom_range(63)) << 2;
      end
      if (!dh && $urandom_range(2) == 0) begin
        dh = 1; rw = 1'($urandom_range(1));
        rb = 4'($urandom_range(15, 1));
        rda = 32'($urandom_range(63)) << 2; rwd = $urandom;
      end
      rsp = busy ? ($urandom_range(1) == 1) : ($urandom_range(3) == 0);
      cyc(ih, ra, dh, rw, rb, rda, rwd, rsp);
      if (m_ig) ih = 0;
      if (m_dg) dh = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
